pdm_mic_sampler: RTL

Microphone front-end for the on-board PDM microphone. Generates the microphone clock, synchronises and samples the 1-bit PDM stream, and decimates it by window counting into unsigned WIDTH-bit PCM samples with a one-cycle valid strobe. Sits directly upstream of the clap detector, which consumes `sample_o`/`sample_valid_o` instead of driving the microphone pins itself.

---
 rtl/pdm_mic_sampler.sv | 79 +++++++
 1 files changed

// File: rtl/pdm_mic_sampler.sv
// PDM microphone front-end: M_CLK generation, 2-flop input sync, window-count decimation.
// Optional `PDM_MAG_EN adds a registered |ones - 2^(WIDTH-1)| magnitude output on mag_o.
module pdm_mic_sampler #(
  parameter int CLK_DIV = 50,
  parameter int WIDTH   = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             M_DATA,
  output logic             M_CLK,
  output logic             M_LRSEL,
  output logic [WIDTH-1:0] sample_o,
  output logic             sample_valid_o,
  output logic [WIDTH-1:0] mag_o
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]    div_cnt;
  logic [1:0]       sync;
  logic [WIDTH-1:0] bit_cnt;
  logic [WIDTH:0]   ones;
  logic             div_wrap;
  logic             rise;
  logic             last;
  logic [WIDTH:0]   total;
  logic [WIDTH-1:0] sat;

  assign M_LRSEL  = 1'b0;
  assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));
  assign rise     = div_wrap && !M_CLK;
  assign last     = rise && (bit_cnt == '1);
  // Window total including the bit sampled on this rise event.
  assign total    = ones + {{WIDTH{1'b0}}, sync[1]};
  assign sat      = total[WIDTH] ? '1 : total[WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt        <= '0;
      M_CLK          <= 1'b0;
      sync           <= '0;
      bit_cnt        <= '0;
      ones           <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      sync           <= {sync[0], M_DATA};
      sample_valid_o <= last;
      if (div_wrap) begin
        div_cnt <= '0;
        M_CLK   <= ~M_CLK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (rise) begin
        bit_cnt <= bit_cnt + 1'b1;
        ones    <= last ? '0 : total;
      end
      if (last) sample_o <= sat;
    end
  end

`ifdef PDM_MAG_EN
  localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] mag_d;

  // Distance from 50% density on the unsaturated total; max is HALF, fits WIDTH bits.
  assign mag_d = (total >= HALF) ? WIDTH'(total - HALF) : WIDTH'(HALF - total);

  always_ff @(posedge clk_i) begin
    if (rst_i)     mag_o <= '0;
    else if (last) mag_o <= mag_d;
  end
`else
  assign mag_o = '0;
`endif

endmodule
